// File: rtl/hazard_stall_unit.sv
// Pipeline interlock controller: load-use and HI/LO divider stalls, taken-branch
// flushes, and a saturating stall-cycle counter for the 5-stage core.
module hazard_stall_unit #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_IsStore,
  input  logic             ID_HiLoUse,
  input  logic             EX_MemRd,
  input  logic [4:0]       EX_RegDstAddr,
  input  logic             EX_DivStart,
  input  logic             EX_BranchTaken,
  output logic             PC_Stall,
  output logic             IFID_Stall,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             DivBusy,
  output logic             HiLoWr,
  output logic [CNT_W-1:0] StallCnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  div_state_t state, state_next;
  logic [5:0] div_cnt, div_cnt_next;
  logic       load_use, div_hazard, stall;

  // Store data (rt of a store) is excluded: the MEM-stage forward supplies it.
  always_comb begin
    load_use = EX_MemRd && (EX_RegDstAddr != 5'd0) &&
               ((ID_UseRs && (ID_rs == EX_RegDstAddr)) ||
                (ID_UseRt && !ID_IsStore && (ID_rt == EX_RegDstAddr)));
    div_hazard = ID_HiLoUse && (state == BUSY);
    stall      = (load_use || div_hazard) && !EX_BranchTaken;
  end

  always_comb begin
    PC_Stall   = stall;
    IFID_Stall = stall;
    IFID_Flush = EX_BranchTaken;
    IDEX_Flush = stall || EX_BranchTaken;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= 6'd0;
    end else begin
      state   <= state_next;
      div_cnt <= div_cnt_next;
    end
  end

  // DONE is busy but not hazardous, so the waiting consumer leaves ID as HI/LO is written.
  always_comb begin
    state_next   = state;
    div_cnt_next = div_cnt;
    DivBusy      = 1'b0;
    HiLoWr       = 1'b0;
    case (state)
      IDLE: begin
        if (EX_DivStart) begin
          state_next   = BUSY;
          div_cnt_next = 6'(DIV_CYCLES - 1);
        end
      end
      BUSY: begin
        DivBusy = 1'b1;
        if (div_cnt == 6'd0) begin
          state_next = DONE;
        end else begin
          div_cnt_next = div_cnt - 6'd1;
        end
      end
      DONE: begin
        DivBusy    = 1'b1;
        HiLoWr     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      StallCnt <= '0;
    end else if (stall && (StallCnt != {CNT_W{1'b1}})) begin
      StallCnt <= StallCnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline interlock controller for the 5-stage core: the stall/bubble side of the load-data hazard path, complementing the MEM-stage store-data forwarding. It detects load-use hazards between EX and ID, and tracks the multi-cycle HI/LO divider so that younger HI/LO consumers wait. It also applies taken-branch flushes and keeps a saturating stall-cycle performance counter. It sits beside the ID stage and drives the PC, IF/ID and ID/EX pipeline-register controls.

## Interface
- DIV_CYCLES, 32: divider busy cycles per operation (legal range 2..63)
- CNT_W, 16: width of the stall performance counter
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- ID_rs, ID_rt  in  5 each  source register fields of the instruction in ID
- ID_UseRs, ID_UseRt  in  1 each  ID instruction actually reads rs / rt
- ID_IsStore  in  1  ID instruction is a store (its rt is the store data)
- ID_HiLoUse  in  1  ID instruction is mfhi/mflo/mult/div (touches HI/LO)
- EX_MemRd  in  1  EX instruction is a load
- EX_RegDstAddr  in  5  EX destination register
- EX_DivStart  in  1  EX instruction launches a divide this cycle
- EX_BranchTaken  in  1  branch/jump resolved taken in EX
- PC_Stall  out  1  hold PC
- IFID_Stall  out  1  hold IF/ID
- IFID_Flush  out  1  clear IF/ID to a NOP
- IDEX_Flush  out  1  insert a bubble into ID/EX
- DivBusy  out  1  divider FSM not IDLE
- HiLoWr  out  1  one-cycle pulse: divider result valid, write HI/LO
- StallCnt  out  CNT_W  count of stall cycles since reset, saturating

## Operation
- Load-use hazard (combinational) is LU = EX_MemRd & (EX_RegDstAddr != 0) & ((ID_UseRs & ID_rs == EX_RegDstAddr) | (ID_UseRt & ~ID_IsStore & ID_rt == EX_RegDstAddr)).
  - Store rt is excluded because the MEM-stage forward covers it.
- Divider hazard: DH = ID_HiLoUse & (state == BUSY).
- Stall condition: STALL = (LU | DH) & ~EX_BranchTaken. When STALL is true:
  - PC_Stall = 1, IFID_Stall = 1, IDEX_Flush = 1.
- Flush condition: when EX_BranchTaken = 1:
  - IFID_Flush = 1, IDEX_Flush = 1, PC_Stall = 0, IFID_Stall = 0.
  - A flush always overrides a stall, because the stalled instruction is being killed.
- Divider FSM states and transitions:
  - IDLE → BUSY on EX_DivStart; the counter loads DIV_CYCLES-1.
  - BUSY: the counter decrements each cycle. At counter 0 → DONE.
  - DONE: HiLoWr = 1 for one cycle, then → IDLE. DivBusy = 1 in BUSY and in DONE.
  - EX_DivStart seen in BUSY or DONE is ignored. It cannot occur legally because DH stalls any HI/LO instruction.
  - In DONE, DH = 0, so the waiting consumer is released in the same cycle that HI/LO is written. The register file write-through provides the value.
- A divide in flight continues across a taken-branch flush, because the divide is older than the branch.
- StallCnt increments by 1 on each cycle with STALL = 1 and holds at all-ones.
- The counter is 6 bits and is internal.

## Timing
- LU, DH, STALL and all flush/stall outputs are combinational from inputs and current state, with zero latency.
- A load-use stall lasts exactly 1 cycle. In the next cycle the load is in MEM, EX holds a bubble (EX_MemRd = 0), and the hazard clears.
- Divide with EX_DivStart at cycle t:
  - BUSY for cycles t+1 .. t+DIV_CYCLES.
  - DONE / HiLoWr at cycle t+DIV_CYCLES+1.
  - IDLE from t+DIV_CYCLES+2.
- Reset values: state IDLE, counter 0, StallCnt 0, DivBusy 0, HiLoWr 0.
  - The combinational outputs then follow their equations with state IDLE.
- rst asserted mid-divide: the FSM goes to IDLE on the next edge and no HiLoWr pulse is produced.
- rst has priority over EX_DivStart in the same cycle.

## Test plan
- Load-use: EX_MemRd = 1, EX_RegDstAddr = 8, ID_UseRs = 1, ID_rs = 8 → PC_Stall, IFID_Stall and IDEX_Flush are 1 for one cycle; StallCnt goes 0 → 1. Repeat with EX_RegDstAddr = 0 → no stall.
- Load then store: EX_MemRd = 1, EX_RegDstAddr = 9, ID_IsStore = 1, ID_UseRt = 1, ID_rt = 9, ID_UseRs = 0 → no stall. Set ID_rs = 9, ID_UseRs = 1 → stall.
- Divide with DIV_CYCLES = 32 and EX_DivStart at cycle 10:
  - DivBusy = 1 during cycles 11–43; HiLoWr = 1 only in cycle 43.
  - ID_HiLoUse = 1 from cycle 12 → stall during cycles 12–42 and released in cycle 43; StallCnt = 31.
- Stall plus branch: LU = 1 and EX_BranchTaken = 1 in the same cycle → IFID_Flush = 1, IDEX_Flush = 1, PC_Stall = 0, and StallCnt unchanged.
- Reset mid-divide: rst asserted at cycle t+5 of a divide → IDLE and DivBusy = 0 at t+6, no HiLoWr pulse. With rst and EX_DivStart together → remains IDLE.
- Saturation: with CNT_W = 4, hold LU = 1 for 20 cycles → StallCnt stops at 15.
